vga_fifo_wr_ctrl: RTL

Write-side controller for the dual-clock BRAM pixel FIFO in the VGA synchronization core. It accepts pixels from the frame generator over a valid/ready handshake and tracks x/y position across an HSIZE×VSIZE frame. It tags the first pixel of each frame with a start-of-frame bit and writes `{sof, color}` words into the FIFO. It throttles on almost-full, waits out FIFO reset recovery, and handles re-synchronisation requests and frame-aligned stop.

---
 rtl/vga_fifo_pkg.sv | 22 ++
 rtl/pix_xy_counter.sv | 57 +++++
 rtl/vga_fifo_wr_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/vga_fifo_pkg.sv
// Shared types and constants for the VGA pixel FIFO write-side controller.
// Provides the controller state encoding, coordinate width, default FIFO
// reset-recovery wait and the position of the start-of-frame bit in a FIFO word.
package vga_fifo_pkg;

  // x/y coordinates are 11-bit unsigned, so frames up to 2048x2048
  localparam int COORD_W      = 11;
  localparam int RST_WAIT_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    STREAM = 2'd2,
    FINISH = 2'd3
  } state_t;

  // FIFO word is {sof, color}: sof sits just above the color bits
  function automatic int sof_bit(input int cd);
    return cd;
  endfunction

endpackage

// File: rtl/pix_xy_counter.sv
// Raster position counter: tracks column/row of the next pixel in an HSIZE x VSIZE frame.
// Ports: clk/reset (sync, active-high), inc_i advances one pixel, clr_i returns to (0,0)
// and wins over inc_i; x_o/y_o current position, last_o at final pixel, first_o at (0,0).
module pix_xy_counter
  import vga_fifo_pkg::*;
#(
  parameter int HSIZE = 640,
  parameter int VSIZE = 480
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc_i,
  input  logic               clr_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               last_o,
  output logic               first_o
);

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(HSIZE - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(VSIZE - 1);

  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr_i) begin
      x_d = '0;
      y_d = '0;
    end else if (inc_i) begin
      if (x_q == X_MAX) begin
        x_d = '0;
        y_d = (y_q == Y_MAX) ? '0 : y_q + COORD_W'(1);
      end else begin
        x_d = x_q + COORD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o     = x_q;
  assign y_o     = y_q;
  assign last_o  = (x_q == X_MAX) && (y_q == Y_MAX);
  assign first_o = (x_q == '0) && (y_q == '0);

endmodule

// File: rtl/vga_fifo_wr_ctrl.sv
// Write-side controller for the VGA pixel FIFO: accepts pixels over valid/ready, tags
// start-of-frame and registers {sof, color} writes (1-cycle latency). Ports: enable/resync
// control, src_* pixel handshake, x/y position, fifo_* write port and flags, frame_done/overflow/busy status.
module vga_fifo_wr_ctrl
  import vga_fifo_pkg::*;
#(
  parameter int CD       = 12,
  parameter int HSIZE    = 640,
  parameter int VSIZE    = 480,
  parameter int RST_WAIT = RST_WAIT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               resync,
  input  logic               src_valid,
  input  logic [CD-1:0]      src_data,
  output logic               src_ready,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  input  logic               fifo_full,
  input  logic               fifo_almost_full,
  output logic               fifo_wr_en,
  output logic [CD:0]        fifo_wr_data,
  output logic               frame_done,
  output logic               overflow,
  output logic               busy
);

  localparam int          SOF_POS   = sof_bit(CD);
  localparam logic [15:0] WAIT_LOAD = 16'(RST_WAIT - 1);

  state_t      state_q, state_d;
  logic [15:0] wait_q, wait_d;
  logic        wr_en_q;
  logic [CD:0] wr_data_q, wr_data_d;
  logic        frame_done_q;
  logic        overflow_q;

  logic active, fire, wrap, ctr_clr, last, first;

  assign active    = (state_q == STREAM) || (state_q == FINISH);
  assign src_ready = active && !fifo_almost_full;
  assign fire      = src_valid && src_ready;
  // A resync in the same cycle as the final pixel restarts the frame instead of completing it
  assign wrap      = fire && last && !resync;
  // Held clear throughout ARM so streaming always begins at (0,0)
  assign ctr_clr   = (state_q == ARM) || (active && resync);

  pix_xy_counter #(
    .HSIZE (HSIZE),
    .VSIZE (VSIZE)
  ) u_xy (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (fire),
    .clr_i   (ctr_clr),
    .x_o     (x),
    .y_o     (y),
    .last_o  (last),
    .first_o (first)
  );

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = ARM;
          wait_d  = WAIT_LOAD;
        end
      end
      ARM: begin
        if (!enable)            state_d = IDLE;
        else if (wait_q == '0)  state_d = STREAM;
        else                    wait_d  = wait_q - 16'd1;
      end
      STREAM: begin
        // Stop request: finish the frame unless this very pixel completes it
        if (!enable) state_d = wrap ? IDLE : FINISH;
      end
      FINISH: begin
        if (wrap)        state_d = IDLE;
        else if (enable) state_d = STREAM;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_data_d          = {1'b0, src_data};
    wr_data_d[SOF_POS] = first;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wait_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      wr_en_q      <= fire;
      frame_done_q <= wrap;
      if (fire) wr_data_q <= wr_data_d;
      if (wr_en_q && fifo_full) overflow_q <= 1'b1;
    end
  end

  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = wr_data_q;
  assign frame_done   = frame_done_q;
  assign overflow     = overflow_q;
  assign busy         = (state_q != IDLE);

endmodule
